// File: rtl/exec_pkg.sv
// Shared definitions for the execute/memory stage: widths, ALU op codes, FSM states.
package exec_pkg;

   localparam int DATA_W   = 8;
   localparam int REG_AW   = 3;
   localparam int IMM_W    = 5;
   localparam int ALU_OP_W = 4;

   localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
   localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
   localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
   localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
   localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
   localparam logic [ALU_OP_W-1:0] ALU_NOT  = 4'd5;
   localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd6;
   localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd7;
   localparam logic [ALU_OP_W-1:0] ALU_ADDI = 4'd8;
   localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd9;
   localparam logic [ALU_OP_W-1:0] ALU_PASS = 4'd10;

   typedef enum logic {
      IDLE     = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for the execute stage. All results wrap at DATA_W; unused op codes yield 0.
module exec_alu
   import exec_pkg::*;
#(
   parameter int DW = DATA_W,
   parameter int IW = IMM_W
) (
   input  logic [ALU_OP_W-1:0] op,
   input  logic [DW-1:0]       a,
   input  logic [DW-1:0]       b,
   input  logic [IW-1:0]       imm,
   output logic [DW-1:0]       result
);

   logic [DW-1:0] imm_ext;
   assign imm_ext = {{(DW-IW){1'b0}}, imm};

   // Op decode; shift amounts only use the low three bits of b.
   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_NOT:  result = ~a;
         ALU_SLL:  result = a << b[2:0];
         ALU_SRL:  result = a >> b[2:0];
         ALU_ADDI: result = a + imm_ext;
         ALU_SLT:  result = {{(DW-1){1'b0}}, (a < b)};
         ALU_PASS: result = b;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/execute_mem_stage.sv
// Execute + memory stage of the 8-bit core: ALU, single outstanding data-memory access
// with timeout, and the registered writeback bundle.
// Optional feature: define FORWARD_EN to bypass the writeback bundle onto the operands.
module execute_mem_stage
   import exec_pkg::*;
#(
   parameter int DW          = DATA_W,
   parameter int AW          = REG_AW,
   parameter int IW          = IMM_W,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                valid_i,
   input  logic [ALU_OP_W-1:0] alucontrol_i,
   input  logic                write_i,
   input  logic                write_data_control_i,
   input  logic                CBwrite_i,
   input  logic [DW-1:0]       rs_data_i,
   input  logic [DW-1:0]       rt_data_i,
   input  logic [AW-1:0]       rs_addr_i,
   input  logic [AW-1:0]       rt_addr_i,
   input  logic [AW-1:0]       write_addr_i,
   input  logic [IW-1:0]       immediate_i,
   input  logic                memread_i,
   input  logic                memwrite_i,
   output logic                stall_o,
   output logic                dmem_req_o,
   output logic                dmem_we_o,
   output logic [DW-1:0]       dmem_addr_o,
   output logic [DW-1:0]       dmem_wdata_o,
   input  logic                dmem_ack_i,
   input  logic [DW-1:0]       dmem_rdata_i,
   output logic                wb_valid_o,
   output logic                wb_write_o,
   output logic [AW-1:0]       wb_addr_o,
   output logic [DW-1:0]       wb_data_o,
   output logic                cb_o,
   output logic                mem_err_o
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   state_t          state;
   logic [CNT_W-1:0] wait_cnt;

   // Instruction bundle held while the memory access is outstanding
   logic            l_write;
   logic            l_wdc;
   logic            l_cbw;
   logic [AW-1:0]   l_waddr;
   logic [DW-1:0]   l_alu;

   logic [DW-1:0]   rs_eff, rt_eff, alu_res, imm_ext, mem_wb_data;
   logic            mem_op;

`ifdef FORWARD_EN
   assign rs_eff = (wb_valid_o && wb_write_o && (wb_addr_o == rs_addr_i)) ? wb_data_o : rs_data_i;
   assign rt_eff = (wb_valid_o && wb_write_o && (wb_addr_o == rt_addr_i)) ? wb_data_o : rt_data_i;
`else
   // ID resolves hazards itself; source addresses are only needed for bypassing.
   logic unused_src_addr;
   assign unused_src_addr = ^{rs_addr_i, rt_addr_i};
   assign rs_eff = rs_data_i;
   assign rt_eff = rt_data_i;
`endif

   assign imm_ext     = {{(DW-IW){1'b0}}, immediate_i};
   assign mem_op      = memread_i | memwrite_i;
   assign stall_o     = (state == MEM_WAIT);
   assign mem_wb_data = l_wdc ? dmem_rdata_i : l_alu;

   exec_alu #(.DW(DW), .IW(IW)) u_alu (
      .op     (alucontrol_i),
      .a      (rs_eff),
      .b      (rt_eff),
      .imm    (immediate_i),
      .result (alu_res)
   );

   // Issue/complete FSM with timeout counter and registered writeback bundle.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         dmem_req_o   <= 1'b0;
         dmem_we_o    <= 1'b0;
         dmem_addr_o  <= '0;
         dmem_wdata_o <= '0;
         wb_valid_o   <= 1'b0;
         wb_write_o   <= 1'b0;
         wb_addr_o    <= '0;
         wb_data_o    <= '0;
         cb_o         <= 1'b0;
         mem_err_o    <= 1'b0;
         l_write      <= 1'b0;
         l_wdc        <= 1'b0;
         l_cbw        <= 1'b0;
         l_waddr      <= '0;
         l_alu        <= '0;
      end else begin
         mem_err_o <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_i && mem_op) begin
                  // Store wins when both memread and memwrite are set
                  dmem_req_o   <= 1'b1;
                  dmem_we_o    <= memwrite_i;
                  dmem_addr_o  <= rs_eff + imm_ext;
                  dmem_wdata_o <= rt_eff;
                  l_write      <= write_i;
                  l_wdc        <= write_data_control_i;
                  l_cbw        <= CBwrite_i;
                  l_waddr      <= write_addr_i;
                  l_alu        <= alu_res;
                  wait_cnt     <= '0;
                  wb_valid_o   <= 1'b0;
                  wb_write_o   <= 1'b0;
                  state        <= MEM_WAIT;
               end else if (valid_i) begin
                  wb_valid_o <= 1'b1;
                  wb_write_o <= write_i;
                  wb_addr_o  <= write_addr_i;
                  wb_data_o  <= alu_res;
                  if (CBwrite_i) cb_o <= |alu_res;
               end else begin
                  wb_valid_o <= 1'b0;
                  wb_write_o <= 1'b0;
               end
            end
            MEM_WAIT: begin
               if (dmem_ack_i) begin
                  // Ack beats timeout when both land on the same cycle
                  dmem_req_o <= 1'b0;
                  dmem_we_o  <= 1'b0;
                  wait_cnt   <= '0;
                  wb_valid_o <= 1'b1;
                  wb_write_o <= dmem_we_o ? 1'b0 : l_write;
                  wb_addr_o  <= l_waddr;
                  wb_data_o  <= mem_wb_data;
                  if (l_cbw) cb_o <= |mem_wb_data;
                  state      <= IDLE;
               end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                  dmem_req_o <= 1'b0;
                  dmem_we_o  <= 1'b0;
                  wait_cnt   <= '0;
                  wb_valid_o <= 1'b1;
                  wb_write_o <= 1'b0;
                  wb_addr_o  <= l_waddr;
                  wb_data_o  <= l_alu;
                  mem_err_o  <= 1'b1;
                  state      <= IDLE;
               end else begin
                  wait_cnt   <= wait_cnt + CNT_W'(1);
                  wb_valid_o <= 1'b0;
                  wb_write_o <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_execute_mem_stage.sv
// Randomised and directed bench for execute_mem_stage against a transaction-level model.
module tb_execute_mem_stage;

   localparam int TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid = 1'b0, wr = 1'b0, wdc = 1'b0, cbw = 1'b0, mrd = 1'b0, mwr = 1'b0, ack = 1'b0;
   logic [3:0] aluc = '0;
   logic [7:0] rs = '0, rt = '0, rdata = '0;
   logic [2:0] rsa = '0, rta = '0, wa = '0;
   logic [4:0] imm = '0;

   logic       stall, req, we, wbv, wbw, cb, err;
   logic [7:0] addr, wdata, wbd;
   logic [2:0] wba;

   int n_checks = 0;
   int n_fail   = 0;

   execute_mem_stage #(.MEM_TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .alucontrol_i(aluc), .write_i(wr),
      .write_data_control_i(wdc), .CBwrite_i(cbw), .rs_data_i(rs), .rt_data_i(rt),
      .rs_addr_i(rsa), .rt_addr_i(rta), .write_addr_i(wa), .immediate_i(imm),
      .memread_i(mrd), .memwrite_i(mwr), .stall_o(stall), .dmem_req_o(req), .dmem_we_o(we),
      .dmem_addr_o(addr), .dmem_wdata_o(wdata), .dmem_ack_i(ack), .dmem_rdata_i(rdata),
      .wb_valid_o(wbv), .wb_write_o(wbw), .wb_addr_o(wba), .wb_data_o(wbd), .cb_o(cb),
      .mem_err_o(err)
   );

   always #5 clk = ~clk;

   wire [33:0] obs = {stall, req, we, addr, wdata, wbv, wbw, wba, wbd, cb, err};

   // Expected outputs
   logic       e_stall = 0, e_req = 0, e_we = 0, e_wbv = 0, e_wbw = 0, e_cb = 0, e_err = 0;
   logic [7:0] e_addr = 0, e_wdata = 0, e_wbd = 0;
   logic [2:0] e_wba = 0;
   // Pending memory transaction in the model
   bit         m_busy = 0;
   int         m_waited = 0;
   logic       l_write = 0, l_wdc = 0, l_cbw = 0;
   logic [2:0] l_waddr = 0;
   logic [7:0] l_alu = 0;

   function automatic [33:0] expv();
      return {e_stall, e_req, e_we, e_addr, e_wdata, e_wbv, e_wbw, e_wba, e_wbd, e_cb, e_err};
   endfunction

   function automatic int ref_alu(int op, int a, int b, int im);
      case (op)
         0: return (a + b) % 256;
         1: return (a - b + 256) % 256;
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return 255 - a;
         6: return (a * (1 << (b % 8))) % 256;
         7: return a / (1 << (b % 8));
         8: return (a + im) % 256;
         9: return (a < b) ? 1 : 0;
         10: return b;
         default: return 0;
      endcase
   endfunction

   // Predict the outputs after the coming clock edge from the current inputs.
   task automatic model_step();
      int a, b, r;
      logic [7:0] md;
      if (!rst_n) begin
         {e_stall, e_req, e_we, e_addr, e_wdata, e_wbv, e_wbw, e_wba, e_wbd, e_cb, e_err} = '0;
         m_busy = 0; m_waited = 0;
      end else begin
         e_err = 0;
         if (!m_busy) begin
            if (valid) begin
               a = int'(rs); b = int'(rt);
`ifdef FORWARD_EN
               if (e_wbv && e_wbw && e_wba == rsa) a = int'(e_wbd);
               if (e_wbv && e_wbw && e_wba == rta) b = int'(e_wbd);
`endif
               r = ref_alu(int'(aluc), a, b, int'(imm));
               if (mrd || mwr) begin
                  e_req = 1; e_we = mwr;
                  e_addr = 8'((a + int'(imm)) % 256); e_wdata = 8'(b);
                  m_busy = 1; m_waited = 0;
                  l_write = wr; l_wdc = wdc; l_cbw = cbw; l_waddr = wa; l_alu = 8'(r);
                  e_wbv = 0; e_wbw = 0;
               end else begin
                  e_wbv = 1; e_wbw = wr; e_wba = wa; e_wbd = 8'(r);
                  if (cbw) e_cb = (r != 0);
               end
            end else begin
               e_wbv = 0; e_wbw = 0;
            end
         end else begin
            m_waited++;
            if (ack) begin
               md = l_wdc ? rdata : l_alu;
               e_wbw = e_we ? 1'b0 : l_write;
               e_req = 0; e_we = 0; m_busy = 0;
               e_wbv = 1; e_wba = l_waddr; e_wbd = md;
               if (l_cbw) e_cb = (md != 0);
            end else if (m_waited == TIMEOUT) begin
               e_req = 0; e_we = 0; m_busy = 0;
               e_wbv = 1; e_wbw = 0; e_wba = l_waddr; e_wbd = l_alu; e_err = 1;
            end else begin
               e_wbv = 0; e_wbw = 0;
            end
         end
         e_stall = m_busy;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      valid = 0; wr = 0; wdc = 0; cbw = 0; mrd = 0; mwr = 0; ack = 0;
      aluc = 0; rs = 0; rt = 0; rsa = 0; rta = 0; wa = 0; imm = 0; rdata = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      for (int i = 0; i < 3; i++) begin
         valid = 1; aluc = 4'($urandom_range(0, 10)); rs = 8'($urandom); rt = 8'($urandom);
         mrd = 1'($urandom); wr = 1;
         tick();
         n_checks++;
         if (obs !== expv()) begin
            n_fail++; $display("FAIL reset: got %h want %h", obs, expv());
         end
      end
      idle_inputs();
      rst_n = 1;
   endtask

   task automatic test_add();
      valid = 1; aluc = 4'd0; rs = 8'hF0; rt = 8'h20; wr = 1; wa = 3'd3; cbw = 1;
      tick();
      idle_inputs();
      n_checks++;
      if (obs !== expv() || wbd !== 8'h10 || wba !== 3'd3 || wbv !== 1'b1) begin
         n_fail++; $display("FAIL add: got %h want %h", obs, expv());
      end
      tick();
      n_checks++;
      if (obs !== expv() || wbv !== 1'b0) begin
         n_fail++; $display("FAIL add_bubble: got %h want %h", obs, expv());
      end
   endtask

   task automatic test_load();
      int stalls = 0;
      valid = 1; mrd = 1; wdc = 1; wr = 1; wa = 3'd4; rs = 8'h10; imm = 5'd5; aluc = 4'd8;
      tick();
      idle_inputs();
      n_checks++;
      if (obs !== expv() || addr !== 8'h15 || req !== 1'b1) begin
         n_fail++; $display("FAIL load_issue: got %h want %h", obs, expv());
      end
      for (int i = 0; i < 3; i++) begin
         if (stall) stalls++;
         if (i == 2) begin ack = 1; rdata = 8'hAB; end
         tick();
         n_checks++;
         if (obs !== expv()) begin
            n_fail++; $display("FAIL load_wait%0d: got %h want %h", i, obs, expv());
         end
      end
      ack = 0;
      n_checks++;
      if (stalls != 3 || wbd !== 8'hAB || wbw !== 1'b1 || stall !== 1'b0) begin
         n_fail++; $display("FAIL load_result: stalls %0d data %h want 3 ab", stalls, wbd);
      end
   endtask

   task automatic test_store();
      valid = 1; mwr = 1; mrd = 1; wr = 1; rs = 8'h00; imm = 5'd2; rt = 8'h5A;
      tick();
      idle_inputs();
      n_checks++;
      if (obs !== expv() || we !== 1'b1 || addr !== 8'h02 || wdata !== 8'h5A) begin
         n_fail++; $display("FAIL store_issue: got %h want %h", obs, expv());
      end
      ack = 1;
      tick();
      ack = 0;
      n_checks++;
      if (obs !== expv() || wbv !== 1'b1 || wbw !== 1'b0) begin
         n_fail++; $display("FAIL store_done: got %h want %h", obs, expv());
      end
   endtask

   // ack_at < 0: never ack; otherwise ack on that MEM_WAIT cycle (1-based)
   task automatic run_wait(input int ack_at, input string name);
      int cyc = 0;
      bit saw_err = 0;
      valid = 1; mrd = 1; wr = 1; wa = 3'd6; rs = 8'h33; imm = 5'd1;
      tick();
      idle_inputs();
      while (stall && cyc < 40) begin
         cyc++;
         ack = (cyc == ack_at);
         rdata = 8'h77;
         tick();
         if (err) saw_err = 1;
         n_checks++;
         if (obs !== expv()) begin
            n_fail++; $display("FAIL %s_cyc%0d: got %h want %h", name, cyc, obs, expv());
         end
      end
      ack = 0;
      n_checks++;
      if (cyc != ((ack_at < 0) ? TIMEOUT : ack_at) || saw_err != (ack_at < 0) || stall) begin
         n_fail++; $display("FAIL %s_len: got %0d cycles err %0d want %0d", name, cyc, saw_err, TIMEOUT);
      end
      tick();
      n_checks++;
      if (obs !== expv() || err !== 1'b0) begin
         n_fail++; $display("FAIL %s_after: got %h want %h", name, obs, expv());
      end
   endtask

   task automatic test_back_to_back();
      valid = 1; mrd = 1; wdc = 1; wr = 1; wa = 3'd1; rs = 8'h40;
      tick();
      valid = 0; ack = 1; rdata = 8'h99;   // ack in first wait cycle
      tick();
      n_checks++;
      if (obs !== expv()) begin
         n_fail++; $display("FAIL b2b_done: got %h want %h", obs, expv());
      end
      valid = 1; mrd = 0; mwr = 1; rs = 8'h08; imm = 5'd3; rt = 8'hC3; ack = 1;
      tick();
      n_checks++;
      if (obs !== expv() || req !== 1'b1 || addr !== 8'h0B) begin
         n_fail++; $display("FAIL b2b_issue: got %h want %h", obs, expv());
      end
      tick();
      idle_inputs();
      // Ack while idle has no effect
      ack = 1; valid = 1; aluc = 4'd10; rt = 8'h21; wr = 1; wa = 3'd2;
      tick();
      idle_inputs();
      n_checks++;
      if (obs !== expv() || wbd !== 8'h21 || req !== 1'b0) begin
         n_fail++; $display("FAIL idle_ack: got %h want %h", obs, expv());
      end
   endtask

   task automatic test_forward();
      logic [7:0] want;
`ifdef FORWARD_EN
      want = 8'h06;
`else
      want = 8'hFF;
`endif
      valid = 1; aluc = 4'd0; rs = 8'h03; rt = 8'h04; wr = 1; wa = 3'd2;
      tick();
      aluc = 4'd1; rsa = 3'd2; rs = 8'h00; rta = 3'd5; rt = 8'h01; wa = 3'd4;
      tick();
      idle_inputs();
      n_checks++;
      if (obs !== expv() || wbd !== want) begin
         n_fail++; $display("FAIL forward: got %h want %h", wbd, want);
      end
   endtask

   task automatic test_reset_mid_wait();
      valid = 1; mrd = 1; wr = 1; rs = 8'h50;
      tick();
      idle_inputs();
      tick();
      rst_n = 0;
      tick();
      n_checks++;
      if (obs !== expv() || obs !== 34'd0) begin
         n_fail++; $display("FAIL rst_mid: got %h want 0", obs);
      end
      rst_n = 1; ack = 1; rdata = 8'hEE;
      tick();
      ack = 0;
      n_checks++;
      if (obs !== expv() || wbv !== 1'b0) begin
         n_fail++; $display("FAIL rst_late_ack: got %h want %h", obs, expv());
      end
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 600; i++) begin
         valid = ($urandom_range(0, 3) != 0);
         aluc  = 4'($urandom);
         rs = 8'($urandom); rt = 8'($urandom); rdata = 8'($urandom);
         rsa = 3'($urandom); rta = 3'($urandom); wa = 3'($urandom); imm = 5'($urandom);
         wr = 1'($urandom); wdc = 1'($urandom);
         mrd = ($urandom_range(0, 3) == 0); mwr = ($urandom_range(0, 5) == 0);
         cbw = !(mrd || mwr) && 1'($urandom);
         ack = ($urandom_range(0, 2) == 0);
         tick();
         n_checks++;
         if (obs !== expv()) begin
            n_fail++; errs++;
            if (errs < 10) $display("FAIL random_%0d: got %h want %h", i, obs, expv());
         end
      end
      idle_inputs();
      for (int i = 0; i < 20; i++) tick();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_add();
      test_load();
      test_store();
      run_wait(-1, "timeout");
      run_wait(TIMEOUT, "ack_on_timeout");
      test_back_to_back();
      test_forward();
      test_reset_mid_wait();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
